datapath_seq: RTL
=================

# datapath_seq

Parametrised, self-sequencing successor to the 16-bit datapath. It holds a reset-clearable register file, A/B operand registers, a shifter, an ALU, a result register C and a status register. One operation is accepted per valid/ready handshake and internally stepped through read-A, read-B, execute and write-back, with a one-cycle done pulse. It sits between the instruction controller and memory: the controller issues decoded operations, and memory supplies `mdata`.

## Interface
Parameters:
- `W`, 16: datapath width in bits; must be ≥ 8.
- `NREG`, 8: register count; must be a power of 2 and ≥ 2. `RW = log2(NREG)`.
- `PCW`, 8: PC width; must be ≤ `W`.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  high only in IDLE.
- `alu_op`  in  2  00 ADD (A+B), 01 SUB (A−B), 10 AND (A&B), 11 MVN (~B).
- `shift`  in  2  applied to B: 00 none, 01 LSL 1, 10 LSR 1, 11 ASR 1.
- `vsel`  in  2  write-back source: 00 C, 01 zero-extended `pc`, 10 `imm`, 11 `mdata`.
- `asel`  in  1  1 forces A operand to 0.
- `bsel`  in  1  1 selects `imm` as B operand, bypassing the shifter.
- `wr_en`  in  1  write back to `rd` in WB.
- `loads`  in  1  update status in EXEC.
- `rd`, `rn`, `rm`  in  RW each  destination, A-source and B-source registers.
- `imm`  in  W  immediate, already sign-extended.
- `pc`  in  PCW  program counter.
- `mdata`  in  W  memory read data.
- `done`  out  1  one-cycle pulse during WB.
- `c_out`  out  W  register C.
- `status`  out  3  {V, N, Z}.

## Operation
- FSM states and transitions:
  - IDLE → RDA on accept (`req_valid & req_ready`).
  - RDA → RDB → EXEC → WB → IDLE, each unconditional.
- On accept, all request fields except `mdata` and `pc` are captured. Later input changes do not affect the operation.
- RDA: A ← R[rn].
- RDB: B ← R[rm].
- EXEC:
  - Ain = `asel` ? 0 : A.
  - Bin = `bsel` ? imm : shift(B). ASR replicates the MSB; LSL and LSR fill with 0.
  - C ← ALU(Ain, Bin), arithmetic modulo 2^W.
  - If `loads`:
    - Z = (result == 0).
    - N = result[W-1].
    - V = signed overflow for ADD/SUB; 0 for AND/MVN.
- WB:
  - `done` = 1.
  - If `wr_en`, R[rd] ← source selected by `vsel`. `pc` and `mdata` are sampled at the WB edge. vsel=00 writes the C value computed in EXEC.
- `rd` may equal `rn` or `rm`; reads always see pre-operation values.
- `c_out` and `status` hold their values between operations.

## Timing
- Accept edge = cycle 0. RDA is cycle 1, RDB cycle 2, EXEC cycle 3, WB cycle 4 (`done` high). `req_ready` is high again in cycle 5.
- Throughput: one operation per 5 cycles when `req_valid` is held high.
- `c_out` is valid from the EXEC edge (start of cycle 4).
- The register-file write is visible to an operation accepted in cycle 5 or later.
- `req_ready` is a combinational decode of state == IDLE. `done` is a registered decode of state == WB.
- Reset (asynchronous, any time) forces:
  - state IDLE;
  - all R[i], A, B, C = 0;
  - `status` = 000;
  - `done` = 0.
- Reset mid-operation aborts it with no write-back. `req_ready` = 1 after reset deasserts.
- While reset is high, requests are ignored.

## Test plan
- Reset, then write R3 ← imm 0x0042 (vsel=10, wr_en=1). Then ADD asel=1, rm=3, shift=00, loads=1. Required: `c_out` = 0x0042, status = 000.
- R1 = 0x7FFF, R2 = 0xFFFF. SUB rn=1, rm=2, loads=1. Required: `c_out` = 0x8000, status = {V=1, N=1, Z=0}. Repeat with loads=0: status unchanged.
- R4 = 0x8004. ADD asel=1, rm=4:
  - shift=11 → `c_out` = 0xC002.
  - shift=01 on 0x8001 → 0x0002.
  - shift=10 on 0x8004 → 0x4002.
- `req_valid` held high for three operations. Required:
  - accepts at cycles 0, 5, 10;
  - `req_ready` low in cycles 1–4;
  - `done` high only in cycles 4, 9, 14;
  - request fields changed after accept have no effect.
- Assert reset in EXEC of a write to R5 (previously 0x1234). Required:
  - R5 = 0 (reset), no write-back;
  - `done` never pulses;
  - `c_out` = 0, `status` = 000.
- With W=32, NREG=16: write R15 ← imm 0x7FFFFFFF, then ADD rn=15 bsel=1 imm=1, loads=1. Required: `c_out` = 0x80000000, status = {1, 1, 0}. Also vsel=01 with `pc` = 0xA5 writes 0x000000A5.

Source files
------------

// File: rtl/datapath_seq.sv
// datapath_seq
// Self-sequencing W-bit datapath: register file, A/B operand registers,
// B-side shifter, ALU, result register C and {V,N,Z} status register.
// Each accepted request runs IDLE -> RDA -> RDB -> EXEC -> WB -> IDLE.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   alu_op, shift       ALU function, shift applied to B
//   vsel                write-back source (C, pc, imm, mdata)
//   asel, bsel          force A to 0, select imm as B
//   wr_en, loads        write back to rd, update status
//   rd, rn, rm          destination, A-source, B-source registers
//   imm, pc, mdata      immediate, program counter, memory read data
//   done                one-cycle pulse during WB
//   c_out, status       register C and {V,N,Z}
module datapath_seq #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     alu_op,
  input  logic [1:0]     shift,
  input  logic [1:0]     vsel,
  input  logic           asel,
  input  logic           bsel,
  input  logic           wr_en,
  input  logic           loads,
  input  logic [RW-1:0]  rd,
  input  logic [RW-1:0]  rn,
  input  logic [RW-1:0]  rm,
  input  logic [W-1:0]   imm,
  input  logic [PCW-1:0] pc,
  input  logic [W-1:0]   mdata,
  output logic           done,
  output logic [W-1:0]   c_out,
  output logic [2:0]     status
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;

  state_t state, state_next;

  logic [W-1:0]  regs [NREG];
  logic [W-1:0]  a_reg, b_reg;

  logic [1:0]    op_alu, op_shift, op_vsel;
  logic          op_asel, op_bsel, op_wr_en, op_loads;
  logic [RW-1:0] op_rd, op_rn, op_rm;
  logic [W-1:0]  op_imm;

  logic [W-1:0]  a_in, b_shift, b_in, result, wb_value;
  logic          ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = RDA;
      end
      RDA:     state_next = RDB;
      RDB:     state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done is registered so it is high for exactly the cycle spent in WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state_next == WB);
  end

  // The whole request (except pc and mdata, which are sampled at WB) is
  // frozen at accept so later input changes cannot disturb the operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_alu   <= '0;
      op_shift <= '0;
      op_vsel  <= '0;
      op_asel  <= 1'b0;
      op_bsel  <= 1'b0;
      op_wr_en <= 1'b0;
      op_loads <= 1'b0;
      op_rd    <= '0;
      op_rn    <= '0;
      op_rm    <= '0;
      op_imm   <= '0;
    end else if (req_valid && req_ready) begin
      op_alu   <= alu_op;
      op_shift <= shift;
      op_vsel  <= vsel;
      op_asel  <= asel;
      op_bsel  <= bsel;
      op_wr_en <= wr_en;
      op_loads <= loads;
      op_rd    <= rd;
      op_rn    <= rn;
      op_rm    <= rm;
      op_imm   <= imm;
    end
  end

  always_comb begin
    a_in    = op_asel ? '0 : a_reg;
    b_shift = b_reg;
    unique case (op_shift)
      2'b00: b_shift = b_reg;
      2'b01: b_shift = {b_reg[W-2:0], 1'b0};
      2'b10: b_shift = {1'b0, b_reg[W-1:1]};
      2'b11: b_shift = {b_reg[W-1], b_reg[W-1:1]};
      default: b_shift = b_reg;
    endcase
    b_in = op_bsel ? op_imm : b_shift;

    // Signed overflow: for ADD the operands agree in sign and the result
    // does not; for SUB the operands differ and the result leaves A's sign.
    result = '0;
    ovf    = 1'b0;
    unique case (op_alu)
      2'b00: begin
        result = a_in + b_in;
        ovf    = (a_in[W-1] == b_in[W-1]) && (result[W-1] != a_in[W-1]);
      end
      2'b01: begin
        result = a_in - b_in;
        ovf    = (a_in[W-1] != b_in[W-1]) && (result[W-1] != a_in[W-1]);
      end
      2'b10: result = a_in & b_in;
      2'b11: result = ~b_in;
      default: result = '0;
    endcase
  end

  always_comb begin
    wb_value = c_out;
    unique case (op_vsel)
      2'b00: wb_value = c_out;
      2'b01: wb_value = W'(pc);
      2'b10: wb_value = op_imm;
      2'b11: wb_value = mdata;
      default: wb_value = c_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      c_out  <= '0;
      status <= 3'b000;
    end else begin
      if (state == RDA) a_reg <= regs[op_rn];
      if (state == RDB) b_reg <= regs[op_rm];
      if (state == EXEC) begin
        c_out <= result;
        if (op_loads) status <= {ovf, result[W-1], (result == '0)};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == WB && op_wr_en) begin
      regs[op_rd] <= wb_value;
    end
  end

endmodule
